// File: rtl/core_sequencer.sv
// core_sequencer: registered core decoder with stall handshake and nested forward bracket search.
// Optional retire counter is enabled by defining CORE_SEQ_RETIRE_CNT_EN.
package core_seq_pkg;
    typedef enum logic [3:0] {NOP, INC, DEC, MVR, MVL, PSH, POP, CBF, CBB} op_code;
    typedef enum logic [1:0] {CORE_S, STALL_S, BRANCH_S} core_state_e;
    typedef enum logic {DISABLE, ENABLE} enable_e;
    typedef enum logic {MEM_READ, MEM_WRITE} mem_op_e;
    typedef enum logic [1:0] {ALU_PASS, ALU_INC, ALU_DEC} alu_op_e;
    typedef enum logic {PC_INCREMENTED, PC_LOADED} pc_src_e;
    typedef struct packed {
        core_state_e state;
        logic        pc_write;
        enable_e     acc_write;
        enable_e     addr_write;
        enable_e     stack_write;
        enable_e     loader_select;
        mem_op_e     mem_op;
        alu_op_e     alu_op;
        pc_src_e     pc_src;
    } control_bundle_f;
endpackage

module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int DEPTH_W   = 8,
    parameter int STALL_MIN = 1,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  op_code              instruction,
    input  logic                acc_zero,
    input  logic                mem_ready,
    output control_bundle_f     controls,
    output logic                pc_write,
    output logic [DEPTH_W-1:0]  nest_depth,
    output logic                depth_err,
    output logic [CNT_W-1:0]    retire_cnt
);
    localparam int STALL_W = $clog2(STALL_MIN + 1);

    core_state_e          r_state, w_next;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [DEPTH_W-1:0]   r_depth, w_depth_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_stall_done;

    assign w_stall_done = r_stall_cnt >= STALL_W'(STALL_MIN - 1);
    assign nest_depth   = r_depth;
    assign depth_err    = r_err;

    always_comb begin
        w_next      = r_state;
        w_depth_nxt = r_depth;
        w_err_nxt   = r_err;
        pc_write    = 1'b0;
        controls    = '{state: r_state, pc_write: 1'b0, acc_write: DISABLE, addr_write: DISABLE,
                        stack_write: DISABLE, loader_select: DISABLE, mem_op: MEM_READ,
                        alu_op: ALU_PASS, pc_src: PC_INCREMENTED};
        case (r_state)
            CORE_S: if (instr_valid) begin
                case (instruction)
                    INC: begin
                        controls.acc_write = ENABLE;
                        controls.mem_op    = MEM_WRITE;
                        controls.alu_op    = ALU_INC;
                        pc_write           = 1'b1;
                    end
                    DEC: begin
                        controls.acc_write = ENABLE;
                        controls.mem_op    = MEM_WRITE;
                        controls.alu_op    = ALU_DEC;
                        pc_write           = 1'b1;
                    end
                    MVR: begin
                        controls.addr_write = ENABLE;
                        controls.alu_op     = ALU_INC;
                        pc_write            = 1'b1;
                    end
                    MVL: begin
                        controls.addr_write = ENABLE;
                        controls.alu_op     = ALU_DEC;
                        pc_write            = 1'b1;
                    end
                    PSH: begin
                        controls.stack_write = ENABLE;
                        pc_write             = 1'b1;
                    end
                    POP, CBB: begin
                        controls.acc_write = ENABLE;
                        w_next             = STALL_S;
                    end
                    CBF: begin
                        controls.acc_write = ENABLE;
                        pc_write           = acc_zero;
                        w_next             = acc_zero ? BRANCH_S : STALL_S;
                        w_depth_nxt        = '0;
                    end
                    default: pc_write = 1'b1;
                endcase
            end
            STALL_S: if (w_stall_done && mem_ready) begin
                pc_write = 1'b1;
                w_next   = CORE_S;
            end
            BRANCH_S: if (instr_valid) begin
                pc_write = 1'b1;
                // Nesting saturates instead of wrapping; the sticky flag records the overflow.
                if (instruction == CBF) begin
                    w_depth_nxt = &r_depth ? r_depth : r_depth + DEPTH_W'(1);
                    w_err_nxt   = r_err | (&r_depth);
                end else if (instruction == CBB) begin
                    w_depth_nxt = r_depth == '0 ? r_depth : r_depth - DEPTH_W'(1);
                    w_next      = r_depth == '0 ? CORE_S : BRANCH_S;
                end
            end
            default: w_next = CORE_S;
        endcase
        controls.pc_write = pc_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CORE_S;
            r_depth     <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_depth     <= w_depth_nxt;
            r_err       <= w_err_nxt;
            r_stall_cnt <= r_state != STALL_S ? '0 :
                           r_stall_cnt < STALL_W'(STALL_MIN) ? r_stall_cnt + STALL_W'(1) : r_stall_cnt;
        end
    end

`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retire <= '0;
        else if (pc_write && r_state != BRANCH_S)
            r_retire <= r_retire + CNT_W'(1);
    end
    assign retire_cnt = r_retire;
`else
    assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer (DEPTH_W=2, STALL_MIN=3).
module tb_core_sequencer;
    import core_seq_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, acc_zero = 1'b0, mem_ready = 1'b0;
    op_code instruction = NOP;
    control_bundle_f controls;
    logic pc_write, depth_err;
    logic [1:0] nest_depth;
    logic [7:0] retire_cnt;

    core_sequencer #(.DEPTH_W(2), .STALL_MIN(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
        .acc_zero(acc_zero), .mem_ready(mem_ready), .controls(controls), .pc_write(pc_write),
        .nest_depth(nest_depth), .depth_err(depth_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pw;
        core_state_e st;
        logic [1:0]  dep;
        enable_e     acc;
        mem_op_e     mop;
        alu_op_e     alu;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0, exp_ret = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input op_code op, input logic az, input logic mr,
                        input logic pw, input core_state_e st, input logic [1:0] dep,
                        input enable_e acc = DISABLE, input mem_op_e mop = MEM_READ, input alu_op_e alu = ALU_PASS);
        @(negedge clk);
        instr_valid = v;
        instruction = op;
        acc_zero    = az;
        mem_ready   = mr;
        sb.push_back('{tag: tag, pw: pw, st: st, dep: dep, acc: acc, mop: mop, alu: alu});
        if (pw && st != BRANCH_S) exp_ret++;
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".pw"}, 32'(pc_write), 32'(e.pw));
            check({e.tag, ".ctl_pw"}, 32'(controls.pc_write), 32'(e.pw));
            check({e.tag, ".state"}, 32'(controls.state), 32'(e.st));
            check({e.tag, ".depth"}, 32'(nest_depth), 32'(e.dep));
            check({e.tag, ".acc_write"}, 32'(controls.acc_write), 32'(e.acc));
            check({e.tag, ".mem_op"}, 32'(controls.mem_op), 32'(e.mop));
            check({e.tag, ".alu_op"}, 32'(controls.alu_op), 32'(e.alu));
            check({e.tag, ".loader"}, 32'(controls.loader_select), 32'(DISABLE));
            check({e.tag, ".pc_src"}, 32'(controls.pc_src), 32'(PC_INCREMENTED));
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst.state", 32'(controls.state), 32'(CORE_S));
        check("rst.pw", 32'(pc_write), 32'd0);
        check("rst.depth", 32'(nest_depth), 32'd0);
        check("rst.err", 32'(depth_err), 32'd0);
        check("rst.retire", 32'(retire_cnt), 32'd0);
        rst_n = 1'b1;

        step("inc", 1, INC, 0, 0, 1, CORE_S, 0, ENABLE, MEM_WRITE, ALU_INC);
        step("idle", 0, INC, 0, 0, 0, CORE_S, 0);
        step("dec", 1, DEC, 0, 0, 1, CORE_S, 0, ENABLE, MEM_WRITE, ALU_DEC);
        step("mvr", 1, MVR, 0, 0, 1, CORE_S, 0, DISABLE, MEM_READ, ALU_INC);
        step("pop", 1, POP, 0, 1, 0, CORE_S, 0, ENABLE);
        step("stall0", 0, NOP, 0, 1, 0, STALL_S, 0);
        step("stall1", 1, INC, 0, 1, 0, STALL_S, 0);
        step("stall2", 0, NOP, 0, 1, 1, STALL_S, 0);
        step("nop", 1, NOP, 0, 0, 1, CORE_S, 0);
        step("cbb", 1, CBB, 0, 0, 0, CORE_S, 0, ENABLE);
        for (int i = 0; i < 4; i++) step("late", 0, NOP, 0, 0, 0, STALL_S, 0);
        step("late_rdy", 0, NOP, 0, 1, 1, STALL_S, 0);
        step("cbf_nz", 1, CBF, 0, 0, 0, CORE_S, 0, ENABLE);
        step("nz_s0", 0, NOP, 0, 1, 0, STALL_S, 0);
        step("nz_s1", 0, NOP, 0, 1, 0, STALL_S, 0);
        step("nz_s2", 0, NOP, 0, 1, 1, STALL_S, 0);

        step("cbf_z", 1, CBF, 1, 0, 1, CORE_S, 0, ENABLE);
        step("b_cbf", 1, CBF, 0, 0, 1, BRANCH_S, 0);
        step("b_inc", 1, INC, 0, 0, 1, BRANCH_S, 1);
        step("b_idle", 0, CBB, 0, 0, 0, BRANCH_S, 1);
        step("b_cbb", 1, CBB, 0, 0, 1, BRANCH_S, 1);
        step("b_dec", 1, DEC, 0, 0, 1, BRANCH_S, 0);
        step("b_exit", 1, CBB, 0, 0, 1, BRANCH_S, 0);
        step("post", 1, INC, 0, 0, 1, CORE_S, 0, ENABLE, MEM_WRITE, ALU_INC);

        step("cbf_z2", 1, CBF, 1, 0, 1, CORE_S, 0, ENABLE);
        step("sat0", 1, CBF, 0, 0, 1, BRANCH_S, 0);
        step("sat1", 1, CBF, 0, 0, 1, BRANCH_S, 1);
        step("sat2", 1, CBF, 0, 0, 1, BRANCH_S, 2);
        #3 check("sat.err_before", 32'(depth_err), 32'd0);
        step("sat3", 1, CBF, 0, 0, 1, BRANCH_S, 3);
        step("sat4", 1, CBF, 0, 0, 1, BRANCH_S, 3);
        #3 check("sat.err_set", 32'(depth_err), 32'd1);
        step("un3", 1, CBB, 0, 0, 1, BRANCH_S, 3);
        step("un2", 1, CBB, 0, 0, 1, BRANCH_S, 2);
        step("un1", 1, CBB, 0, 0, 1, BRANCH_S, 1);
        step("un0", 1, CBB, 0, 0, 1, BRANCH_S, 0);
        step("after", 1, NOP, 0, 0, 1, CORE_S, 0);
        #3 check("sat.err_sticky", 32'(depth_err), 32'd1);
        step("quiet", 0, NOP, 0, 0, 0, CORE_S, 0);
        @(negedge clk);
        #3;
`ifdef CORE_SEQ_RETIRE_CNT_EN
        check("retire", 32'(retire_cnt), 32'(exp_ret & 8'hff));
`else
        check("retire_off", 32'(retire_cnt), 32'd0);
`endif

        step("pop2", 1, POP, 0, 0, 0, CORE_S, 0, ENABLE);
        step("rs0", 0, NOP, 0, 0, 0, STALL_S, 0);
        step("rs1", 0, NOP, 0, 0, 0, STALL_S, 0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1 check("rs.pre_pw", 32'(pc_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rs.state", 32'(controls.state), 32'(CORE_S));
        check("rs.pw", 32'(pc_write), 32'd0);
        check("rs.depth", 32'(nest_depth), 32'd0);
        check("rs.err", 32'(depth_err), 32'd0);
        check("rs.retire", 32'(retire_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
